// File: rtl/audio_pkg.sv
// Shared types and constants for the step sequencer: note table, pattern entry layout and FSM states.
package audio_pkg;

    localparam int STEPS  = 16;
    localparam int STEP_W = $clog2(STEPS);

    // Index 3 is a silent slot: a valid step that plays nothing audible.
    localparam logic [31:0] NOTE_FREQ [4] = '{32'd700, 32'd882, 32'd1049, 32'd0};

    typedef struct packed {
        logic       valid;
        logic [1:0] note;
    } step_entry_t;

    localparam step_entry_t EMPTY_ENTRY = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CHK,
        ST_WR,
        ST_ADV
    } seq_state_t;

    function automatic logic [31:0] entry_freq(input step_entry_t entry);
        return entry.valid ? NOTE_FREQ[entry.note] : 32'd0;
    endfunction

endpackage

// File: rtl/pattern_ram.sv
// 16x3 pattern store: registered read, synchronous write, single-cycle clear that overrides a write.
module pattern_ram
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STEP_W-1:0] rd_addr,
    output step_entry_t       rd_data,
    input  logic              wr_en,
    input  logic [STEP_W-1:0] wr_addr,
    input  step_entry_t       wr_data,
    input  logic              clr
);

    step_entry_t mem [STEPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mem[i] <= EMPTY_ENTRY;
            end
            rd_data <= EMPTY_ENTRY;
        end else begin
            rd_data <= mem[rd_addr];
            if (clr) begin
                for (int i = 0; i < STEPS; i++) begin
                    mem[i] <= EMPTY_ENTRY;
                end
            end else if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// 16-step note sequencer: step divider, read/check/write/advance FSM and tone/trigger outputs.
// Optional swing timing is enabled by defining STEP_SEQ_SWING_EN.
module step_sequencer
    import audio_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int STEP_HZ      = 16
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        run,
    input  logic        rec_strobe,
    input  logic [1:0]  rec_note,
    input  logic        erase,
    input  logic        clear,
    output logic [31:0] freq,
    output logic        trig,
    output logic [3:0]  step,
    output logic [15:0] step_onehot
);

    localparam int STEP_CYCLES_RAW = SYS_CLK_FREQ / STEP_HZ;
    localparam int STEP_CYCLES     = (STEP_CYCLES_RAW < 8) ? 8 : STEP_CYCLES_RAW;
`ifdef STEP_SEQ_SWING_EN
    localparam int SWING      = STEP_CYCLES / 4;
    localparam int MAX_PERIOD = STEP_CYCLES + SWING;
`else
    localparam int MAX_PERIOD = STEP_CYCLES;
`endif
    localparam int DIV_W = $clog2(MAX_PERIOD);

    logic              rst_n;
    logic [1:0]        rst_sync;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_limit;
    logic              tick;
    logic [STEP_W-1:0] next_step;
    seq_state_t        state;
    step_entry_t       rd_entry;
    step_entry_t       entry_q;
    step_entry_t       play_q;
    step_entry_t       wr_entry;
    logic              wr_en;
    logic              rec_pending;
    logic [1:0]        rec_note_q;

    // Assertion reaches every register at once; release waits two sys_clk edges.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n     = rst_sync[1];
    assign next_step = step + STEP_W'(1);

`ifdef STEP_SEQ_SWING_EN
    assign div_limit = next_step[0] ? DIV_W'(STEP_CYCLES - SWING - 1)
                                    : DIV_W'(STEP_CYCLES + SWING - 1);
`else
    assign div_limit = DIV_W'(STEP_CYCLES - 1);
`endif

    assign tick = run && (div_cnt == div_limit);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (run) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        wr_entry = entry_q;
        if (erase) begin
            wr_entry = EMPTY_ENTRY;
        end else if (rec_pending) begin
            wr_entry = '{valid: 1'b1, note: rec_note_q};
        end
    end

    assign wr_en = (state == ST_WR);

    pattern_ram u_pattern_ram (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .rd_addr (next_step),
        .rd_data (rd_entry),
        .wr_en   (wr_en),
        .wr_addr (next_step),
        .wr_data (wr_entry),
        .clr     (clear)
    );

    // A strobe in the WR cycle is applied last so it survives that step's pending clear.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            step        <= 4'd15;
            step_onehot <= 16'h8000;
            freq        <= '0;
            trig        <= 1'b0;
            entry_q     <= EMPTY_ENTRY;
            play_q      <= EMPTY_ENTRY;
            rec_pending <= 1'b0;
            rec_note_q  <= 2'b00;
        end else begin
            trig <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    state <= ST_CHK;
                end
                ST_CHK: begin
                    entry_q <= rd_entry;
                    state   <= ST_WR;
                end
                ST_WR: begin
                    play_q      <= wr_entry;
                    rec_pending <= 1'b0;
                    state       <= ST_ADV;
                end
                ST_ADV: begin
                    step        <= next_step;
                    step_onehot <= 16'(1) << next_step;
                    freq        <= entry_freq(play_q);
                    trig        <= play_q.valid;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (rec_strobe) begin
                rec_pending <= 1'b1;
                rec_note_q  <= rec_note;
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer at STEP_CYCLES=10: expected steps are queued by the stimulus
// process and checked by a monitor whenever the step output advances.
module tb_step_sequencer;

    localparam int SYS_CLK_FREQ = 160;
    localparam int STEP_HZ      = 16;
    localparam int DROP_K       = 70;
    localparam int DROP_LEN     = 37;
    localparam int LAST_K       = 81;

    typedef struct {
        int step_idx;
        int freq_hz;
        int trig_hi;
        int at_cyc;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        run;
    logic        rec_strobe;
    logic [1:0]  rec_note;
    logic        erase;
    logic        clear;
    logic [31:0] freq;
    logic        trig;
    logic [3:0]  step;
    logic [15:0] step_onehot;

    int   cyc;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [3:0]  last_step = 4'd15;
    logic [31:0] last_freq = 32'd0;

    step_sequencer #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .STEP_HZ      (STEP_HZ)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .run         (run),
        .rec_strobe  (rec_strobe),
        .rec_note    (rec_note),
        .erase       (erase),
        .clear       (clear),
        .freq        (freq),
        .trig        (trig),
        .step        (step),
        .step_onehot (step_onehot)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
        end
    end

    function automatic int step_period(input int j);
`ifdef STEP_SEQ_SWING_EN
        return (j % 2 == 0) ? 12 : 8;
`else
        return 10;
`endif
    endfunction

    // Cycle number (counted from reset release) in which the tick for play index k occurs.
    function automatic int tick_cyc(input int k);
        int t;
        t = 1;
        for (int j = 0; j <= k; j++) begin
            t += step_period(j);
        end
        if (k > DROP_K) begin
            t += DROP_LEN;
        end
        return t;
    endfunction

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cyc %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic push_exp(input int k, input int freq_hz, input int trig_hi);
        exp_t e;
        e.step_idx = k % 16;
        e.freq_hz  = freq_hz;
        e.trig_hi  = trig_hi;
        e.at_cyc   = tick_cyc(k) + 5;
        exp_q.push_back(e);
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(negedge sys_clk);
        end
    endtask

    task automatic apply_stimulus(input logic strobe, input logic [1:0] note,
                                  input logic era, input logic clr);
        rec_strobe = strobe;
        rec_note   = note;
        erase      = era;
        clear      = clr;
    endtask

    task automatic pulse_strobe(input int n, input logic [1:0] note);
        at_cycle(n);
        apply_stimulus(1'b1, note, erase, 1'b0);
        at_cycle(n + 1);
        apply_stimulus(1'b0, note, erase, 1'b0);
    endtask

    always @(negedge sys_clk) begin
        if (!reset) begin
            last_step = 4'd15;
            last_freq = 32'd0;
        end else if (step !== last_step) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_step", int'(step), int'(last_step));
            end else begin
                mon_e = exp_q.pop_front();
                check_output("step", int'(step), mon_e.step_idx);
                check_output("step_onehot", int'(step_onehot), 1 << mon_e.step_idx);
                check_output("freq", int'(freq), mon_e.freq_hz);
                check_output("trig", int'(trig), mon_e.trig_hi);
                check_output("step_time", cyc, mon_e.at_cyc);
            end
            last_step = step;
            last_freq = freq;
        end else begin
            check_output("freq_hold", int'(freq), int'(last_freq));
            check_output("trig_width", int'(trig), 0);
        end
    end

    initial begin
        run = 1'b1;
        apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_output("reset_step", int'(step), 15);
        check_output("reset_onehot", int'(step_onehot), 32'h8000);
        check_output("reset_freq", int'(freq), 0);
        check_output("reset_trig", int'(trig), 0);

        for (int k = 0; k <= LAST_K; k++) begin
            case (k)
                0, 16, 81: push_exp(k, 882, 1);
                19, 50:    push_exp(k, 1049, 1);
                48:        push_exp(k, 700, 1);
                default:   push_exp(k, 0, 0);
            endcase
        end
        reset = 1'b1;

        pulse_strobe(3, 2'd1);
        pulse_strobe(tick_cyc(18) + 6, 2'd2);

        at_cycle(tick_cyc(31) + 4);
        apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0);
        at_cycle(tick_cyc(47) + 3);
        apply_stimulus(1'b1, 2'd0, 1'b1, 1'b0);
        at_cycle(tick_cyc(47) + 4);
        apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0);

        pulse_strobe(tick_cyc(49) + 3, 2'd2);
        at_cycle(tick_cyc(50) + 3);
        apply_stimulus(1'b0, 2'd2, 1'b0, 1'b1);
        at_cycle(tick_cyc(50) + 4);
        apply_stimulus(1'b0, 2'd2, 1'b0, 1'b0);

        at_cycle(tick_cyc(DROP_K) + 1);
        run = 1'b0;
        at_cycle(tick_cyc(DROP_K) + 1 + DROP_LEN);
        run = 1'b1;

        pulse_strobe(tick_cyc(80) + 6, 2'd1);
        pulse_strobe(tick_cyc(81) + 5, 2'd1);

        // Abort in the middle of the CHK cycle of the next step, with a record still pending.
        at_cycle(tick_cyc(LAST_K + 1) + 2);
        check_output("queue_drained", exp_q.size(), 0);
        reset = 1'b0;
        #1;
        check_output("abort_step", int'(step), 15);
        check_output("abort_onehot", int'(step_onehot), 32'h8000);
        check_output("abort_freq", int'(freq), 0);
        check_output("abort_trig", int'(trig), 0);
        repeat (4) @(negedge sys_clk);
        push_exp(0, 0, 0);
        push_exp(1, 0, 0);
        reset = 1'b1;
        at_cycle(tick_cyc(1) + 8);
        check_output("final_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        checks++;
        $display("[TB] FAIL watchdog: got timeout, expected completion (queue %0d)", exp_q.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
